// File: rtl/cpu_multicycle_ctrl_pkg.sv
// Shared opcode map, FSM state encoding and write-back source encodings for the multi-cycle controller.
package cpu_ctrl_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_IMM = 2'd1;
  localparam logic [1:0] WSEL_MEM = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu_multicycle_ctrl_pc_reg.sv
// Program counter: synchronous reset to 0, +1 on inc, wraps modulo 2^PC_W.
module cpu_pc_reg #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle control FSM: fetch into IR, sequence ALU / write-back / data-memory strobes.
// Define CPU_CTRL_RETIRE_CNT_EN to add the 16-bit retired-instruction counter output.
module cpu_multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W = 9,
  parameter int IW   = INSTR_W
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic [IW-1:0]   ir,
  input  logic [3:0]      opcode,
  output logic            alu_en,
  output logic            reg_we,
  output logic [1:0]      reg_wsel,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
`ifdef CPU_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]     retired
`endif
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] wsel_nxt;
  logic       illegal_nxt;
  logic       fetch_done;

  assign fetch_done = (state == S_FETCH) && imem_ack;
  assign imem_addr  = pc;

  cpu_pc_reg #(.PC_W(PC_W)) u_pc (
    .clk (clk),
    .rst (rst),
    .inc (fetch_done),
    .pc  (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      ir       <= '0;
      reg_wsel <= WSEL_ALU;
      illegal  <= 1'b0;
    end else begin
      state    <= state_nxt;
      reg_wsel <= wsel_nxt;
      illegal  <= illegal_nxt;
      if (fetch_done) begin
        ir <= imem_rdata;
      end
    end
  end

  // reg_wsel is chosen at decode so it is already valid in EXEC/MEM and holds through WB.
  always_comb begin
    state_nxt   = state;
    wsel_nxt    = reg_wsel;
    illegal_nxt = illegal;
    imem_req    = 1'b0;
    alu_en      = 1'b0;
    reg_we      = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        wsel_nxt = WSEL_ALU;
        case (opcode)
          OP_NOP:  state_nxt = S_FETCH;
          OP_ADD:  state_nxt = S_EXEC;
          OP_LDI: begin
            state_nxt = S_EXEC;
            wsel_nxt  = WSEL_IMM;
          end
          OP_LD: begin
            state_nxt = S_MEM;
            wsel_nxt  = WSEL_MEM;
          end
          OP_ST:   state_nxt = S_MEM;
          OP_HALT: state_nxt = S_HALT;
          default: begin
            state_nxt   = S_FETCH;
            illegal_nxt = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        alu_en    = (opcode == OP_ADD);
        state_nxt = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_ST);
        if (dmem_ack) state_nxt = (opcode == OP_ST) ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic retire;

  assign retire = ((state_nxt == S_FETCH) &&
                   ((state == S_DECODE) || (state == S_WB) || (state == S_MEM))) ||
                  ((state_nxt == S_HALT) && (state != S_HALT));

  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Directed bench: ADD/LD/ST/LDI/illegal/HALT program, reset mid-MEM, and PC wrap on a PC_W=3 instance.
module tb_cpu_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [8:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic        alu_en;
  logic        reg_we;
  logic [1:0]  reg_wsel;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [8:0]  pc;
  logic        halted;
  logic        illegal;

  logic        rst_w;
  logic [2:0]  imem_addr_w;
  logic        imem_req_w;
  logic        imem_ack_w;
  logic [15:0] imem_rdata_w;
  logic [15:0] ir_w;
  logic [3:0]  opcode_w;
  logic        alu_en_w;
  logic        reg_we_w;
  logic [1:0]  reg_wsel_w;
  logic        dmem_req_w;
  logic        dmem_we_w;
  logic        dmem_ack_w;
  logic [2:0]  pc_w;
  logic        halted_w;
  logic        illegal_w;
`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [15:0] retired;
  logic [15:0] retired_w;
`endif

  logic [15:0] rom [0:511];
  int          n_cmp;
  int          n_bad;
  int          req_seen;

  assign imem_rdata = rom[imem_addr];
  assign opcode     = ir[15:12];
  assign opcode_w   = ir_w[15:12];

  cpu_multicycle_ctrl #(.PC_W(9), .IW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .opcode     (opcode),
    .alu_en     (alu_en),
    .reg_we     (reg_we),
    .reg_wsel   (reg_wsel),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal)
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    .retired    (retired)
`endif
  );

  cpu_multicycle_ctrl #(.PC_W(3), .IW(16)) dut_w (
    .clk        (clk),
    .rst        (rst_w),
    .imem_addr  (imem_addr_w),
    .imem_req   (imem_req_w),
    .imem_ack   (imem_ack_w),
    .imem_rdata (imem_rdata_w),
    .ir         (ir_w),
    .opcode     (opcode_w),
    .alu_en     (alu_en_w),
    .reg_we     (reg_we_w),
    .reg_wsel   (reg_wsel_w),
    .dmem_req   (dmem_req_w),
    .dmem_we    (dmem_we_w),
    .dmem_ack   (dmem_ack_w),
    .pc         (pc_w),
    .halted     (halted_w),
    .illegal    (illegal_w)
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    .retired    (retired_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1298;
    rom[1] = 16'h3205;
    rom[2] = 16'h4005;
    rom[3] = 16'h2123;
    rom[4] = 16'h7000;
    rom[5] = 16'hF000;

    rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0;
    rst_w = 1'b1; imem_ack_w = 1'b1; imem_rdata_w = 16'h0000; dmem_ack_w = 1'b0;
    tick(); tick();
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_wsel", reg_wsel, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);

    // ADD, immediate fetch ack
    rst = 1'b0;
    check("add_c0_imem_req", imem_req, 1);
    check("add_c0_addr", imem_addr, 0);
    tick();
    check("add_c1_ir", ir, 16'h1298);
    check("add_c1_pc", pc, 1);
    check("add_c1_imem_req", imem_req, 0);
    tick();
    check("add_c2_alu_en", alu_en, 1);
    check("add_c2_reg_we", reg_we, 0);
    tick();
    check("add_c3_reg_we", reg_we, 1);
    check("add_c3_wsel", reg_wsel, 0);
    check("add_c3_alu_en", alu_en, 0);
    tick();
    check("add_c4_imem_req", imem_req, 1);
    check("add_c4_reg_we", reg_we, 0);

    // LD with dmem_ack arriving on the 4th MEM cycle
    tick();
    check("ld_ir", ir, 16'h3205);
    check("ld_pc", pc, 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ack = 1'b1;
      check($sformatf("ld_mem%0d_req", i), dmem_req, 1);
      check($sformatf("ld_mem%0d_we", i), dmem_we, 0);
      check($sformatf("ld_mem%0d_imem_req", i), imem_req, 0);
      check($sformatf("ld_mem%0d_reg_we", i), reg_we, 0);
      tick();
    end
    dmem_ack = 1'b0;
    check("ld_wb_reg_we", reg_we, 1);
    check("ld_wb_wsel", reg_wsel, 2);
    check("ld_wb_dmem_req", dmem_req, 0);
    tick();
    check("ld_done_reg_we", reg_we, 0);
    check("ld_done_imem_req", imem_req, 1);

    // ST with immediate ack
    dmem_ack = 1'b1;
    tick();
    check("st_ir", ir, 16'h4005);
    tick();
    check("st_mem_req", dmem_req, 1);
    check("st_mem_we", dmem_we, 1);
    check("st_mem_reg_we", reg_we, 0);
    tick();
    dmem_ack = 1'b0;
    check("st_done_dmem_req", dmem_req, 0);
    check("st_done_imem_req", imem_req, 1);
    check("st_done_reg_we", reg_we, 0);
    check("st_done_pc", pc, 3);

    // LDI
    tick();
    tick();
    check("ldi_exec_alu_en", alu_en, 0);
    check("ldi_exec_wsel", reg_wsel, 1);
    tick();
    check("ldi_wb_reg_we", reg_we, 1);
    check("ldi_wb_wsel", reg_wsel, 1);
    tick();
    check("ldi_done_pc", pc, 4);

    // Fetch stall: pc and ir hold, request stays up
    imem_ack = 1'b0;
    tick(); tick();
    check("stall_pc", pc, 4);
    check("stall_ir", ir, 16'h2123);
    check("stall_imem_req", imem_req, 1);
    imem_ack = 1'b1;

    // Illegal opcode 0x7
    tick();
    check("ill_dec_pc", pc, 5);
    check("ill_dec_illegal", illegal, 0);
    tick();
    check("ill_illegal", illegal, 1);
    check("ill_reg_we", reg_we, 0);
    check("ill_dmem_req", dmem_req, 0);
    check("ill_imem_req", imem_req, 1);

    // HALT
    tick(); tick();
    check("halt_halted", halted, 1);
    check("halt_imem_req", imem_req, 0);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req || dmem_req) req_seen++;
      tick();
    end
    check("halt_no_req", req_seen, 0);
    check("halt_still", halted, 1);
    check("halt_illegal_sticky", illegal, 1);
    check("halt_pc", pc, 6);
`ifdef CPU_CTRL_RETIRE_CNT_EN
    check("retired_prog", retired, 6);
`endif

    // Reset out of HALT, then reset in the middle of a stalled LD
    rom[0] = 16'h3205;
    rst = 1'b1;
    tick();
    check("rst2_halted", halted, 0);
    check("rst2_illegal", illegal, 0);
    check("rst2_pc", pc, 0);
    rst = 1'b0;
    tick(); tick();
    check("mid_mem_dmem_req", dmem_req, 1);
    rst = 1'b1; dmem_ack = 1'b1;
    tick();
    check("rstmem_dmem_req", dmem_req, 0);
    check("rstmem_reg_we", reg_we, 0);
    check("rstmem_pc", pc, 0);
    check("rstmem_imem_req", imem_req, 1);
    check("rstmem_illegal", illegal, 0);
    check("rstmem_halted", halted, 0);
    rst = 1'b0;
    tick();
    check("late_ack_dmem_req", dmem_req, 0);
    check("late_ack_pc", pc, 1);
    dmem_ack = 1'b0;

    // PC_W = 3: eight NOPs wrap pc 7 -> 0
    rst_w = 1'b0;
    check("w_start_pc", pc_w, 0);
    repeat (14) tick();
    check("w_pc7", pc_w, 7);
    repeat (2) tick();
    check("w_pc_wrap", pc_w, 0);
    check("w_addr_wrap", imem_addr_w, 0);
    check("w_reg_we", reg_we_w, 0);
`ifdef CPU_CTRL_RETIRE_CNT_EN
    check("w_retired", retired_w, 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
